bcd_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for binary-to-BCD conversion using the double-dabble (shift-add-3) algorithm, one iteration per clock.
- Sits between the ALU result register and the display/readout logic.
- Accepts a binary word over a valid/ready handshake, iterates DWIDTH cycles, then holds the BCD result until the consumer accepts it.
- Replaces the single-cycle combinational converter on timing-critical paths.

---
 rtl/bcd_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_bcd_seq_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_ctrl.sv
// Multi-cycle binary-to-BCD converter (double dabble, one shift-add-3 step per clock)
// with a valid/ready handshake on both sides and saturation to all nines on overflow.
module bcd_seq_ctrl #(
    parameter int DWIDTH = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DWIDTH-1:0]     bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic                  busy
);

    // Handshakes: a word moves on a rising edge where valid and ready are both high;
    // the producer holds data stable while valid is high and ready is low.

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DWIDTH + 1);
    localparam logic [CW-1:0] LAST  = CW'(DWIDTH - 1);
    localparam logic [BW-1:0] NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [DWIDTH-1:0] sr;
    logic [DWIDTH-1:0] sr_next;
    logic [BW-1:0]     acc;
    logic [BW-1:0]     adj;
    logic [BW-1:0]     acc_next;
    logic [CW-1:0]     cnt;
    logic              ovf;
    logic              ovf_next;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = CONV;
            CONV: if (cnt == LAST) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: in_ready  = 1'b1;
            CONV: busy      = 1'b1;
            DONE: out_valid = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    // Per-digit add-3 with no carry into the next digit, then shift the binary MSB in.
    always_comb begin
        adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        acc_next = {adj[BW-2:0], sr[DWIDTH-1]};
        sr_next  = sr << 1;
        // A set top bit after adjust would be shifted out and lost.
        ovf_next = ovf | adj[BW-1];
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr       <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sr  <= bin_in;
                        acc <= '0;
                        cnt <= '0;
                        ovf <= 1'b0;
                    end
                end
                CONV: begin
                    sr  <= sr_next;
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    ovf <= ovf_next;
                    if (cnt == LAST) begin
                        bcd_out  <= ovf_next ? NINES : acc_next;
                        overflow <= ovf_next;
                    end
                end
                default: begin
                    sr <= sr;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Directed bench for bcd_seq_ctrl: a 3-digit and a 2-digit instance share the same
// stimulus so saturation can be observed alongside the normal result.
module tb_bcd_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [7:0]  bin_in = '0;
    logic        in_ready, out_valid, overflow, busy;
    logic [11:0] bcd_out;
    logic        in_ready2, out_valid2, overflow2, busy2;
    logic [7:0]  bcd_out2;

    int cmp = 0;
    int err = 0;
    int cyc = 0;

    bcd_seq_ctrl #(.DWIDTH(8), .DIGITS(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .bin_in(bin_in),
        .out_valid(out_valid), .out_ready(out_ready), .bcd_out(bcd_out),
        .overflow(overflow), .busy(busy)
    );

    bcd_seq_ctrl #(.DWIDTH(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .bin_in(bin_in),
        .out_valid(out_valid2), .out_ready(out_ready), .bcd_out(bcd_out2),
        .overflow(overflow2), .busy(busy2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Waits for in_ready, offers v, and returns the result once out_valid rises.
    // lat counts edges from the accepting edge to the first out_valid sample.
    task automatic do_conv(input logic [7:0] v, output logic [11:0] res, output logic ovf,
                           output int lat, output int acc_cyc);
        int k = 0;
        while (!in_ready && k < 20) begin step(); k++; end
        in_valid = 1'b1;
        bin_in   = v;
        step();
        acc_cyc  = cyc;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin step(); lat++; end
        res = bcd_out;
        ovf = overflow;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        cmp++; if (bcd_out !== 12'h000) begin err++; $display("FAIL reset_bcd: got %h want 000", bcd_out); end
        cmp++; if ({out_valid, overflow, busy} !== 3'b000) begin err++; $display("FAIL reset_flags: got %b want 000", {out_valid, overflow, busy}); end
        rst = 1'b0;
        step();
        cmp++; if (in_ready !== 1'b1) begin err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        int k;
        in_valid  = 1'b1;
        bin_in    = 8'd255;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        cmp++; if ({in_ready, busy} !== 2'b01) begin err++; $display("FAIL basic_accept: in_ready,busy got %b want 01", {in_ready, busy}); end
        k = 0;
        while (!out_valid && k < 40) begin step(); k++; end
        cmp++; if (k !== 8) begin err++; $display("FAIL basic_latency: got %0d want 8", k); end
        cmp++; if (bcd_out !== 12'h255) begin err++; $display("FAIL basic_bcd: got %h want 255", bcd_out); end
        cmp++; if (overflow !== 1'b0) begin err++; $display("FAIL basic_ovf: got %b want 0", overflow); end
        step();
        cmp++; if ({out_valid, in_ready} !== 2'b01) begin err++; $display("FAIL basic_release: out_valid,in_ready got %b want 01", {out_valid, in_ready}); end
    endtask

    task automatic test_values();
        logic [7:0]  vin [5]  = '{8'd0, 8'd99, 8'd100, 8'd9, 8'd10};
        logic [11:0] vexp [5] = '{12'h000, 12'h099, 12'h100, 12'h009, 12'h010};
        logic [11:0] res;
        logic ovf;
        int lat, ac;
        for (int i = 0; i < 5; i++) begin
            do_conv(vin[i], res, ovf, lat, ac);
            cmp++; if (res !== vexp[i]) begin err++; $display("FAIL values_%0d: got %h want %h", vin[i], res, vexp[i]); end
            cmp++; if (lat !== 8) begin err++; $display("FAIL values_lat_%0d: got %0d want 8", vin[i], lat); end
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [11:0] res;
        logic ovf;
        int lat, ac, bad;
        out_ready = 1'b0;
        do_conv(8'd137, res, ovf, lat, ac);
        cmp++; if (res !== 12'h137) begin err++; $display("FAIL bp_bcd: got %h want 137", res); end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            bin_in   = 8'd7;
            step();
            if (out_valid !== 1'b1 || bcd_out !== 12'h137 || in_ready !== 1'b0 || busy !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        cmp++; if (bad !== 0) begin err++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
        out_ready = 1'b1;
        step();
        cmp++; if ({out_valid, in_ready, busy} !== 3'b010) begin err++; $display("FAIL bp_release: got %b want 010", {out_valid, in_ready, busy}); end
        cmp++; if (bcd_out !== 12'h137) begin err++; $display("FAIL bp_retain: got %h want 137", bcd_out); end
    endtask

    task automatic test_overflow();
        logic [11:0] res;
        logic ovf;
        int lat, ac;
        do_conv(8'd100, res, ovf, lat, ac);
        cmp++; if ({overflow2, bcd_out2} !== {1'b1, 8'h99}) begin err++; $display("FAIL ovf_sat: got %b/%h want 1/99", overflow2, bcd_out2); end
        cmp++; if ({ovf, res} !== {1'b0, 12'h100}) begin err++; $display("FAIL ovf_wide: got %b/%h want 0/100", ovf, res); end
        do_conv(8'd42, res, ovf, lat, ac);
        cmp++; if ({overflow2, bcd_out2} !== {1'b0, 8'h42}) begin err++; $display("FAIL ovf_clear: got %b/%h want 0/42", overflow2, bcd_out2); end
        step();
    endtask

    task automatic test_abort();
        logic [11:0] res;
        logic ovf;
        int lat, ac, seen;
        in_valid = 1'b1;
        bin_in   = 8'd200;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        cmp++; if (bcd_out !== 12'h000) begin err++; $display("FAIL abort_bcd: got %h want 000", bcd_out); end
        cmp++; if ({out_valid, overflow, busy, overflow2} !== 4'b0000) begin err++; $display("FAIL abort_flags: got %b want 0000", {out_valid, overflow, busy, overflow2}); end
        step();
        step();
        rst = 1'b0;
        step();
        cmp++; if (in_ready !== 1'b1) begin err++; $display("FAIL abort_in_ready: got %b want 1", in_ready); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid !== 1'b0) seen++;
        end
        cmp++; if (seen !== 0) begin err++; $display("FAIL abort_no_valid: got %0d want 0", seen); end
        do_conv(8'd58, res, ovf, lat, ac);
        cmp++; if (res !== 12'h058) begin err++; $display("FAIL abort_fresh: got %h want 058", res); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [11:0] res;
        logic [7:0]  exp2;
        logic ovf;
        int lat, ac, prev_ac, bad_val, bad_lat, bad_gap, bad_ovf;
        bad_val = 0; bad_lat = 0; bad_gap = 0; bad_ovf = 0; prev_ac = 0;
        out_ready = 1'b1;
        for (int v = 0; v < 256; v++) begin
            do_conv(8'(v), res, ovf, lat, ac);
            exp2 = (v > 99) ? 8'h99 : ref_bcd(v)[7:0];
            if (res !== ref_bcd(v) || ovf !== 1'b0) begin
                bad_val++;
                if (bad_val <= 4) $display("FAIL b2b_value_%0d: got %h want %h", v, res, ref_bcd(v));
            end
            if (bcd_out2 !== exp2 || overflow2 !== (v > 99)) bad_ovf++;
            if (lat !== 8) bad_lat++;
            if (v > 0 && ac - prev_ac !== 10) bad_gap++;
            prev_ac = ac;
        end
        cmp++; if (bad_val !== 0) begin err++; $display("FAIL b2b_values: got %0d wrong want 0", bad_val); end
        cmp++; if (bad_ovf !== 0) begin err++; $display("FAIL b2b_two_digit: got %0d wrong want 0", bad_ovf); end
        cmp++; if (bad_lat !== 0) begin err++; $display("FAIL b2b_latency: got %0d wrong want 0", bad_lat); end
        cmp++; if (bad_gap !== 0) begin err++; $display("FAIL b2b_period: got %0d wrong want 0", bad_gap); end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_backpressure();
        test_overflow();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule
